// File: rtl/instruction_fetch_requester.sv
// Instruction fetch requester: issues one word request at a time from a PC register,
// hands the captured word to decode, and flags memories that never answer.
module instruction_fetch_requester #(
    parameter int                    ADDRES_BIT     = 32,
    parameter logic [ADDRES_BIT-1:0] RESET_PC       = 32'h8000_0000,
    parameter int                    DATA_BIT       = 32,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [ADDRES_BIT-1:0] address_o,
    output logic                  get_instruction_o,
    input  logic                  instruction_completed_i,
    input  logic [DATA_BIT-1:0]   read_data_i,
    input  logic                  redirect_i,
    input  logic [ADDRES_BIT-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    output logic [DATA_BIT-1:0]   instr_o,
    output logic [ADDRES_BIT-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    output logic                  fetch_error_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_REQUEST = 2'd0,
        S_HOLD    = 2'd1,
        S_ERROR   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDRES_BIT-1:0] r_pc;
    logic [ADDRES_BIT-1:0] w_pc_nxt;
    logic [DATA_BIT-1:0]   r_instr;
    logic [ADDRES_BIT-1:0] r_instr_pc;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [TW-1:0]         r_tcnt;
    logic [TW-1:0]         w_tcnt_nxt;
    logic                  w_capture;
    logic                  w_req;

    // The request is masked while reset is held so memory never sees a stray fetch.
    assign w_req = (r_state == S_REQUEST) && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_REQUEST;
            r_pc    <= RESET_PC;
            r_err   <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_err   <= w_err_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = r_err;
        w_tcnt_nxt  = r_tcnt;
        w_capture   = 1'b0;
        // Redirect wins over everything, including a same-cycle completion or handshake.
        if (redirect_i) begin
            w_state_nxt = S_REQUEST;
            w_pc_nxt    = {redirect_pc_i[ADDRES_BIT-1:2], 2'b00};
            w_err_nxt   = 1'b0;
            w_tcnt_nxt  = '0;
        end else begin
            case (r_state)
                S_REQUEST: begin
                    if (instruction_completed_i) begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + ADDRES_BIT'(4);
                        w_tcnt_nxt  = '0;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TW'(1);
                        if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            w_state_nxt = S_ERROR;
                            w_err_nxt   = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready_i) begin
                        w_state_nxt = S_REQUEST;
                        w_tcnt_nxt  = '0;
                    end
                end
                S_ERROR: begin
                    w_state_nxt = S_ERROR;
                end
                default: begin
                    w_state_nxt = S_REQUEST;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= read_data_i;
            r_instr_pc <= r_pc;
        end
    end

    assign address_o         = r_pc;
    assign get_instruction_o = w_req;
    assign instr_valid_o     = (r_state == S_HOLD);
    assign instr_o           = r_instr;
    assign instr_pc_o        = r_instr_pc;
    assign fetch_error_o     = r_err;

endmodule

// File: tb/tb_instruction_fetch_requester.sv
// Bench for instruction_fetch_requester: a flag-based fetch model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_instruction_fetch_requester;

    localparam int          TO  = 64;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] address_o;
    logic        get_instruction_o;
    logic        instruction_completed_i;
    logic [31:0] read_data_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        fetch_error_o;

    logic comp_auto = 1'b0;
    logic comp_force = 1'b0;
    logic cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    instruction_fetch_requester #(
        .ADDRES_BIT(32), .RESET_PC(RPC), .DATA_BIT(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .address_o(address_o),
        .get_instruction_o(get_instruction_o),
        .instruction_completed_i(instruction_completed_i),
        .read_data_i(read_data_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .instr_valid_o(instr_valid_o),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .fetch_error_o(fetch_error_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign read_data_i             = mem_word(address_o);
    assign instruction_completed_i = comp_force | (comp_auto & get_instruction_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Model: a fetched word is either held for decode, or we are waiting on memory, or stuck in error.
    logic [31:0] m_pc = RPC;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_ipc = 32'h0;
    logic        m_held = 1'b0;
    logic        m_err = 1'b0;
    int          m_wait = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pc <= RPC; m_instr <= 32'h0; m_ipc <= 32'h0;
            m_held <= 1'b0; m_err <= 1'b0; m_wait <= 0;
        end else if (redirect_i) begin
            m_pc <= redirect_pc_i & ~32'h3;
            m_held <= 1'b0; m_err <= 1'b0; m_wait <= 0;
        end else if (m_err) begin
            m_wait <= m_wait;
        end else if (m_held) begin
            if (instr_ready_i) begin
                m_held <= 1'b0; m_wait <= 0;
            end
        end else if (instruction_completed_i) begin
            m_instr <= read_data_i; m_ipc <= m_pc; m_pc <= m_pc + 32'd4;
            m_held <= 1'b1; m_wait <= 0;
        end else begin
            m_wait <= m_wait + 1;
            if (m_wait + 1 >= TO) m_err <= 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("m_address", address_o, m_pc);
            chk1("m_get", get_instruction_o, rst_ni && !m_held && !m_err);
            chk1("m_valid", instr_valid_o, m_held);
            chk1("m_error", fetch_error_o, m_err);
            chk("m_instr", instr_o, m_instr);
            chk("m_instr_pc", instr_pc_o, m_ipc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        instr_ready_i = 1'b1;
        comp_auto     = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk1("rst_get", get_instruction_o, 1'b0);
        chk("rst_addr", address_o, RPC);
        chk1("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        chk1("rst_err", fetch_error_o, 1'b0);
        cmp_en = 1'b1;
        #2 rst_ni = 1'b1;

        // Zero-latency memory, decode always ready.
        @(negedge clk_i);
        chk1("s1_get_first", get_instruction_o, 1'b1);
        chk("s1_addr_first", address_o, 32'h8000_0000);
        @(negedge clk_i);
        chk1("s1_valid", instr_valid_o, 1'b1);
        chk1("s1_get_gap", get_instruction_o, 1'b0);
        chk("s1_instr", instr_o, 32'h0000_0013);
        chk("s1_instr_pc", instr_pc_o, 32'h8000_0000);
        chk("s1_next_pc", address_o, 32'h8000_0004);
        @(negedge clk_i);
        chk1("s1_get_again", get_instruction_o, 1'b1);
        chk1("s1_valid_drop", instr_valid_o, 1'b0);

        // Completion delayed 20 cycles.
        comp_auto = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0000;
        @(negedge clk_i);
        redirect_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk1("s2_get_held", get_instruction_o, 1'b1);
            chk("s2_addr_stable", address_o, 32'h8000_0000);
            chk1("s2_no_err", fetch_error_o, 1'b0);
            if (i == 19) comp_force = 1'b1;
            @(negedge clk_i);
        end
        comp_force = 1'b0;
        chk1("s2_valid", instr_valid_o, 1'b1);
        chk("s2_instr", instr_o, 32'h0000_0013);
        chk("s2_instr_pc", instr_pc_o, 32'h8000_0000);

        // Decode stalls for 5 cycles.
        instr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1("s3_valid_hold", instr_valid_o, 1'b1);
            chk("s3_instr_hold", instr_o, 32'h0000_0013);
            chk1("s3_no_req", get_instruction_o, 1'b0);
            @(negedge clk_i);
        end
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        chk1("s3_req_resume", get_instruction_o, 1'b1);
        chk("s3_addr_resume", address_o, 32'h8000_0004);

        // Redirect coincident with completion drops the data.
        comp_force = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0103;
        @(negedge clk_i);
        comp_force = 1'b0; redirect_i = 1'b0;
        chk("s4_addr", address_o, 32'h8000_0100);
        chk1("s4_valid", instr_valid_o, 1'b0);
        chk("s4_instr_pc_kept", instr_pc_o, 32'h8000_0000);

        // Completion during HOLD is ignored; redirect in HOLD drops the held word.
        comp_auto = 1'b1; instr_ready_i = 1'b0;
        @(negedge clk_i);
        comp_auto = 1'b0; comp_force = 1'b1;
        chk("s5_instr", instr_o, 32'h0100_FEFF);
        chk("s5_instr_pc", instr_pc_o, 32'h8000_0100);
        repeat (2) @(negedge clk_i);
        comp_force = 1'b0;
        chk("s5_ignored_pc", instr_pc_o, 32'h8000_0100);
        chk("s5_ignored_addr", address_o, 32'h8000_0104);
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200; instr_ready_i = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        chk1("s5_valid_drop", instr_valid_o, 1'b0);
        chk("s5_addr", address_o, 32'h8000_0200);

        // No completion at all: timeout after 64 request cycles.
        cnt = 0;
        while (get_instruction_o && cnt < 200) begin
            cnt++;
            @(negedge clk_i);
        end
        chk("s6_timeout_cycles", cnt, 32'd64);
        chk1("s6_err", fetch_error_o, 1'b1);
        chk1("s6_get_low", get_instruction_o, 1'b0);
        comp_force = 1'b1;
        repeat (3) @(negedge clk_i);
        comp_force = 1'b0;
        chk1("s6_err_sticky", fetch_error_o, 1'b1);
        chk1("s6_valid_low", instr_valid_o, 1'b0);
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0010;
        @(negedge clk_i);
        redirect_i = 1'b0;
        chk1("s6_err_clear", fetch_error_o, 1'b0);
        chk1("s6_req_resume", get_instruction_o, 1'b1);
        chk("s6_addr", address_o, 32'h8000_0010);
        comp_auto = 1'b1; instr_ready_i = 1'b0;
        @(negedge clk_i);
        comp_auto = 1'b0;
        chk("s6_instr_pc", instr_pc_o, 32'h8000_0010);

        // PC wrap at the top of the address space, with an unaligned redirect.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        redirect_i = 1'b0;
        chk("s7_addr_aligned", address_o, 32'hFFFF_FFFC);
        comp_auto = 1'b1;
        @(negedge clk_i);
        comp_auto = 1'b0;
        chk("s7_instr_pc", instr_pc_o, 32'hFFFF_FFFC);
        chk("s7_instr", instr_o, 32'hFFFC_0003);
        chk("s7_wrap", address_o, 32'h0000_0000);
        chk1("s7_no_err", fetch_error_o, 1'b0);

        // Asynchronous reset in the middle of HOLD.
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        chk1("s8_valid_async", instr_valid_o, 1'b0);
        chk1("s8_get_async", get_instruction_o, 1'b0);
        chk("s8_addr_async", address_o, 32'h8000_0000);
        chk("s8_instr_async", instr_o, 32'h0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(negedge clk_i);
        chk1("s8_get_release", get_instruction_o, 1'b1);
        chk("s8_addr_release", address_o, 32'h8000_0000);

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_requester.md
INSTRUCTION_FETCH_REQUESTER -- requirements
Module: instruction_fetch_requester

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ADDRES_BIT, default 32, address width.
REQ-003 SHALL have parameter DATA_BIT, default 32, instruction width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, cycles of unanswered request before error.
REQ-005 SHALL have port clk_i  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port address_o  out  ADDRES_BIT  fetch address to instruction memory.
REQ-008 SHALL have port get_instruction_o  out  1  level request to memory.
REQ-009 SHALL have port instruction_completed_i  in  1  memory completion, may be high in the same cycle as the request.
REQ-010 SHALL have port read_data_i  in  DATA_BIT  instruction word, valid only when completion is high.
REQ-011 SHALL have port redirect_i  in  1  branch/jump redirect pulse.
REQ-012 SHALL have port redirect_pc_i  in  ADDRES_BIT  redirect target.
REQ-013 SHALL have port instr_valid_o  out  1  instruction available to decode.
REQ-014 SHALL have port instr_o  out  DATA_BIT  fetched instruction.
REQ-015 SHALL have port instr_pc_o  out  ADDRES_BIT  address of instr_o.
REQ-016 SHALL have port instr_ready_i  in  1  decode accepts instruction.
REQ-017 SHALL have port fetch_error_o  out  1  sticky timeout flag.

Function
REQ-018 SHALL implement FSM states REQUEST, HOLD, ERROR; reset state REQUEST.
REQ-019 SHALL keep register pc; address_o = pc at all times; get_instruction_o = 1 only in REQUEST.
REQ-020 SHALL, in REQUEST with instruction_completed_i=1 and redirect_i=0, capture read_data_i into instr_o, pc into instr_pc_o, set pc = pc+4 (mod 2^ADDRES_BIT), go HOLD.
REQ-021 SHALL sample instruction_completed_i only while get_instruction_o=1; completion outside REQUEST is ignored.
REQ-022 SHALL assert instr_valid_o exactly while in HOLD; instr_o/instr_pc_o stable throughout HOLD.
REQ-023 SHALL, in HOLD with instr_valid_o & instr_ready_i, go REQUEST next cycle; get_instruction_o therefore low at least one cycle between requests (max throughput 1 instr / 2 cycles).
REQ-024 SHALL keep a timeout counter: cleared on entering REQUEST and on completion; +1 per REQUEST cycle without completion; on reaching TIMEOUT_CYCLES go ERROR, set fetch_error_o.
REQ-025 SHALL, in ERROR, hold get_instruction_o=0, instr_valid_o=0; leave only on redirect_i.
REQ-026 SHALL treat redirect_i as highest priority in every state: pc = {redirect_pc_i[ADDRES_BIT-1:2], 2'b00}, instr_valid_o=0, timeout counter and fetch_error_o cleared, next state REQUEST.
REQ-027 SHALL discard read_data_i when completion and redirect_i coincide in REQUEST (no capture, pc from redirect).
REQ-028 SHALL discard a held instruction when redirect_i arrives in HOLD even if instr_ready_i=1 that cycle (no handshake counted).
REQ-029 SHALL, on pc = 32'hFFFF_FFFC completion, wrap pc to 32'h0000_0000 without error.

Reset
REQ-030 SHALL, on rst_ni=0 (immediately, clock-independent), set pc=RESET_PC, state REQUEST, instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_error_o=0, timeout counter=0.
REQ-031 SHALL drive get_instruction_o=0 while rst_ni=0 and assert it the first cycle after release; reset mid-request aborts it with no capture.

Verification
REQ-032 Zero-latency memory, word 0x0000_0013 at 0x8000_0000, ready tied 1 -> get_instruction_o 1,0,1,...; instr_valid_o with instr_o=0x13, instr_pc_o=0x8000_0000, then pc 0x8000_0004.
REQ-033 Completion delayed 20 cycles -> get_instruction_o held 20 cycles, address_o stable 0x8000_0000, one capture, fetch_error_o=0.
REQ-034 instr_ready_i=0 for 5 cycles in HOLD -> instr_valid_o/instr_o stable 5 cycles, no new request until ready.
REQ-035 redirect_i with redirect_pc_i=0x8000_0103 coincident with completion -> data dropped, next address_o=0x8000_0100, instr_valid_o=0.
REQ-036 No completion, TIMEOUT_CYCLES=64 -> fetch_error_o rises after 64 request cycles, get_instruction_o=0; later redirect to 0x8000_0010 clears error, request resumes at 0x8000_0010.
REQ-037 rst_ni pulsed low mid-HOLD asynchronously -> instr_valid_o=0 immediately, address_o=0x8000_0000 after release.
